sram_fifo_ctrl: RTL

- Byte-stream FIFO controller that uses the on-chip SRAM wrapper as backing storage.
- Sits directly upstream of the SRAM wrapper and drives its read enable, write enable, 16-bit address and 8-bit write data. It captures the SRAM's 8-bit read data.
- Presents a valid/ready push port to the producer and a valid/ready pop port to the consumer.
- Storage is a circular region of DEPTH bytes starting at BASE_ADDR.

---
 rtl/sram_fifo_pkg.sv | 18 +
 rtl/sram_fifo_if.sv | 44 ++++
 rtl/sram_fifo_ptr.sv | 28 ++
 rtl/sram_fifo_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared definitions for the SRAM-backed byte FIFO controller.
//   - SRAM bus widths (address and data)
//   - FSM state encoding used by sram_fifo_ctrl
package sram_fifo_pkg;

  localparam int SRAM_ADDR_W = 16;
  localparam int SRAM_DATA_W = 8;

  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
  typedef logic [SRAM_DATA_W-1:0] sram_data_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

endpackage

// File: rtl/sram_fifo_if.sv
// Signal bundle between the FIFO controller, its producer/consumer and the
// SRAM wrapper.
//   flush                 synchronous clear request
//   wr_valid/wr_data      producer push port, wr_ready back-pressure
//   rd_valid/rd_data      consumer pop port, rd_ready acknowledge
//   occupancy/full/empty  fill status
//   sram_*                SRAM wrapper access (read_enable, write_enable,
//                         address, write_data, read_data)
// Modports: master = controller side, slave = surrounding system side.
interface sram_fifo_if import sram_fifo_pkg::*; #(
  parameter int DEPTH = 256
) ();

  localparam int OCC_W = $clog2(DEPTH) + 2;

  logic             flush;
  logic             wr_valid;
  sram_data_t       wr_data;
  logic             wr_ready;
  logic             rd_valid;
  sram_data_t       rd_data;
  logic             rd_ready;
  logic [OCC_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             sram_read;
  logic             sram_write;
  sram_addr_t       sram_addr;
  sram_data_t       sram_wdata;
  sram_data_t       sram_rdata;

  modport master (
    input  flush, wr_valid, wr_data, rd_ready, sram_rdata,
    output wr_ready, rd_valid, rd_data, occupancy, full, empty,
           sram_read, sram_write, sram_addr, sram_wdata
  );

  modport slave (
    output flush, wr_valid, wr_data, rd_ready, sram_rdata,
    input  wr_ready, rd_valid, rd_data, occupancy, full, empty,
           sram_read, sram_write, sram_addr, sram_wdata
  );

endinterface

// File: rtl/sram_fifo_ptr.sv
// Wrapping pointer into the circular SRAM region.
//   clk, rst  clock and asynchronous active-high reset
//   clr       synchronous clear to 0 (wins over inc)
//   inc       advance by one; wraps naturally modulo 2**W
//   ptr       current pointer value
module sram_fifo_ptr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Byte FIFO controller using an external SRAM as a circular buffer of DEPTH
// bytes starting at BASE_ADDR, with a one-byte output register in front of
// the consumer.
//   clk, rst  clock and asynchronous active-high reset
//   bus       sram_fifo_if master: push/pop handshakes, status, SRAM access
// Each push or refill takes one IDLE decision cycle plus one access cycle.
module sram_fifo_ctrl import sram_fifo_pkg::*; #(
  parameter sram_addr_t BASE_ADDR = 16'h0000,
  parameter int         DEPTH     = 256
) (
  input  logic      clk,
  input  logic      rst,
  sram_fifo_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  state_t     state, next_state;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic       rd_valid_q;
  sram_data_t rd_data_q;
  logic       sram_read_q, sram_write_q;
  sram_addr_t sram_addr_q;
  sram_data_t sram_wdata_q;

  logic       slot_free, full_i, wr_ready_i, start_read, start_write;
  sram_addr_t wr_addr, rd_addr;

  // The output register can accept a refill if it is empty or being popped now.
  assign slot_free = !rd_valid_q || bus.rd_ready;
  assign full_i    = (count == CW'(DEPTH));
  assign wr_addr   = BASE_ADDR + sram_addr_t'(wr_ptr);
  assign rd_addr   = BASE_ADDR + sram_addr_t'(rd_ptr);

  // A flushed access still toggles the SRAM, so pointer advances are gated.
  sram_fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk(clk), .rst(rst), .clr(bus.flush),
    .inc((state == WRITE) && !bus.flush), .ptr(wr_ptr)
  );

  sram_fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk(clk), .rst(rst), .clr(bus.flush),
    .inc((state == READ) && !bus.flush), .ptr(rd_ptr)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state  = state;
    start_read  = 1'b0;
    start_write = 1'b0;
    wr_ready_i  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.flush) begin
          // Refilling the output register takes priority over accepting a push.
          if (slot_free && (count != '0)) begin
            start_read = 1'b1;
            next_state = READ;
          end else begin
            wr_ready_i = !full_i;
            if (bus.wr_valid && !full_i) begin
              start_write = 1'b1;
              next_state  = WRITE;
            end
          end
        end
      end
      WRITE:   next_state = IDLE;
      READ:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      sram_read_q  <= 1'b0;
      sram_write_q <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else if (bus.flush) begin
      state        <= IDLE;
      count        <= '0;
      rd_valid_q   <= 1'b0;
      sram_read_q  <= 1'b0;
      sram_write_q <= 1'b0;
    end else begin
      state        <= next_state;
      sram_read_q  <= start_read;
      sram_write_q <= start_write;
      if (start_read) begin
        sram_addr_q <= rd_addr;
      end else if (start_write) begin
        sram_addr_q  <= wr_addr;
        sram_wdata_q <= bus.wr_data;
      end
      case (state)
        WRITE:   count <= count + CW'(1);
        READ:    count <= count - CW'(1);
        default: count <= count;
      endcase
      // READ is entered only when the slot will be empty, so a completing
      // read and a pop never collide.
      if (state == READ) begin
        rd_data_q  <= bus.sram_rdata;
        rd_valid_q <= 1'b1;
      end else if (rd_valid_q && bus.rd_ready) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign bus.wr_ready   = wr_ready_i;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.full       = full_i;
  assign bus.occupancy  = (CW+1)'(count) + (CW+1)'(rd_valid_q);
  assign bus.empty      = (count == '0) && !rd_valid_q;
  assign bus.sram_read  = sram_read_q;
  assign bus.sram_write = sram_write_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;

endmodule
